rr_fixed_latency_sched: RTL and testbench

Round-robin scheduler that shares one fixed-latency resource among NREQ requesters. The resource takes a one-cycle start pulse `a` and must answer with `b` exactly LAT cycles later, the same contract as `a |-> ##LAT b`. The block issues `a` on behalf of the winning requester and checks the `b` timing. It returns a per-requester done pulse, or an error pulse with cause and owner id.

---
 rtl/rr_fixed_latency_sched_pkg.sv | 20 ++
 rtl/rr_fixed_latency_sched_if.sv | 43 ++++
 rtl/rr_fixed_latency_sched_pick.sv | 39 +++
 rtl/rr_fixed_latency_sched.sv | 147 ++++++++++++++
 tb/tb_rr_fixed_latency_sched.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/rr_fixed_latency_sched_pkg.sv
// -----------------------------------------------------------------------------
// rr_sched_pkg
// Shared types for the round-robin fixed-latency scheduler.
//   state_t     : scheduler FSM states (IDLE, WAIT)
//   err_cause_t : why a transaction failed (NONE, EARLY, LATE)
// -----------------------------------------------------------------------------
package rr_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    EARLY = 2'd1,
    LATE  = 2'd2
  } err_cause_t;

endpackage

// File: rtl/rr_fixed_latency_sched_if.sv
// -----------------------------------------------------------------------------
// rr_fixed_latency_sched_if
// Bundles the requester handshake and the resource a/b contract of the
// scheduler.
//   slave  : scheduler side (drives gnt, a, done, err*, busy; samples en, req, b)
//   master : environment side (requesters plus the shared resource)
// Signals:
//   en        issue enable
//   req       level request per requester
//   gnt       one-hot grant pulse, coincident with a
//   a / b     start pulse to resource / resource response
//   done      one-hot completion pulse
//   err       error pulse, qualified by err_early / err_late, owner in err_id
//   busy      a transaction is outstanding
// -----------------------------------------------------------------------------
interface rr_fixed_latency_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) ();

  logic            en;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic            a;
  logic            b;
  logic [NREQ-1:0] done;
  logic            err;
  logic            err_early;
  logic            err_late;
  logic [IDW-1:0]  err_id;
  logic            busy;

  modport slave (
    input  en, req, b,
    output gnt, a, done, err, err_early, err_late, err_id, busy
  );

  modport master (
    output en, req, b,
    input  gnt, a, done, err, err_early, err_late, err_id, busy
  );

endinterface

// File: rtl/rr_fixed_latency_sched_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches req upward starting at ptr+1 and
// wrapping modulo NREQ; the first set bit wins.
//   req    : request vector
//   ptr    : index of the previous winner
//   onehot : one-hot winner (all zero if no request)
//   idx    : winner index (zero if no request)
//   any    : at least one request present
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  always_comb begin
    int j;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    // i runs 1..NREQ so the previous winner is checked last
    for (int i = 1; i <= NREQ; i++) begin
      j = (int'(ptr) + i) % NREQ;
      if (!any && req[j]) begin
        any       = 1'b1;
        onehot[j] = 1'b1;
        idx       = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/rr_fixed_latency_sched.sv
// -----------------------------------------------------------------------------
// rr_fixed_latency_sched
// Shares one fixed-latency resource among NREQ requesters. In IDLE the
// round-robin winner is issued (a + one-hot gnt); in WAIT the response b is
// checked against the a |-> ##LAT b contract. A correct response yields a
// done pulse for the owner; an early or missing b yields an err pulse with
// its cause and owner id. All outputs are registered.
// Ports:
//   clk    : system clock, posedge
//   rst_n  : asynchronous active-low reset
//   bus    : slave modport of rr_fixed_latency_sched_if
// -----------------------------------------------------------------------------
module rr_fixed_latency_sched
  import rr_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  rr_fixed_latency_sched_if.slave        bus
);

  localparam int CW = $clog2(LAT + 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            a_q, a_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            busy_q, busy_d;
  logic            err_q, err_early_q, err_late_q;
  logic [IDW-1:0]  err_id_q, err_id_d;
  err_cause_t      cause_d;

  logic [NREQ-1:0] pick_onehot;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // The counter is loaded with LAT on issue. At edge E it still holds LAT
  // (b ignored), at E+k it holds LAT-k, so cnt==0 marks the decision edge
  // E+LAT and 1..LAT-1 is the early window. It leaves WAIT at 0, never wraps.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    busy_d   = busy_q;
    gnt_d    = '0;
    a_d      = 1'b0;
    done_d   = '0;
    cause_d  = NONE;
    err_id_d = '0;

    case (state_q)
      IDLE: begin
        if (bus.en && pick_any) begin
          a_d     = 1'b1;
          gnt_d   = pick_onehot;
          busy_d  = 1'b1;
          owner_d = pick_idx;
          ptr_d   = pick_idx;
          cnt_d   = CW'(LAT);
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (cnt_q == CW'(LAT)) begin
          cnt_d = cnt_q - 1'b1;
        end else if (cnt_q == '0) begin
          if (bus.b) begin
            done_d[owner_q] = 1'b1;
          end else begin
            cause_d  = LATE;
            err_id_d = owner_q;
          end
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (bus.b) begin
          cause_d  = EARLY;
          err_id_d = owner_q;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= '0;
      ptr_q       <= IDW'(NREQ - 1);
      gnt_q       <= '0;
      a_q         <= 1'b0;
      done_q      <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      err_early_q <= 1'b0;
      err_late_q  <= 1'b0;
      err_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      a_q         <= a_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      err_q       <= (cause_d != NONE);
      err_early_q <= (cause_d == EARLY);
      err_late_q  <= (cause_d == LATE);
      err_id_q    <= err_id_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.a         = a_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;
  assign bus.err_early = err_early_q;
  assign bus.err_late  = err_late_q;
  assign bus.err_id    = err_id_q;

endmodule

// File: tb/tb_rr_fixed_latency_sched.sv
// -----------------------------------------------------------------------------
// tb_rr_fixed_latency_sched
// Directed bench for rr_fixed_latency_sched with NREQ=4, LAT=4.
// Inputs change and outputs are sampled 1 time unit after each posedge.
// -----------------------------------------------------------------------------
module tb_rr_fixed_latency_sched;

  localparam int NREQ = 4;
  localparam int LAT  = 4;
  localparam int IDW  = 2;

  logic clk;
  logic rst_n;

  int pass_cnt;
  int fail_cnt;
  int total_cnt;

  rr_fixed_latency_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  rr_fixed_latency_sched #(
    .NREQ (NREQ),
    .LAT  (LAT),
    .IDW  (IDW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_a"},    32'(bus.a),    32'd0);
    chk({tag, "_gnt"},  32'(bus.gnt),  32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_err"},  32'(bus.err),  32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    pass_cnt  = 0;
    fail_cnt  = 0;
    total_cnt = 0;
    rst_n     = 1'b0;
    bus.en    = 1'b1;
    bus.req   = '0;
    bus.b     = 1'b0;

    // ---------------- reset state
    tick();
    tick();
    chk_quiet("rst");
    chk("rst_err_early", 32'(bus.err_early), 32'd0);
    chk("rst_err_late",  32'(bus.err_late),  32'd0);
    chk("rst_err_id",    32'(bus.err_id),    32'd0);
    rst_n = 1'b1;
    tick();

    // ---------------- 1: normal completion for requester 2
    bus.req = 4'b0100;
    tick();                                    // issue edge
    chk("t1_gnt",  32'(bus.gnt),  32'h4);
    chk("t1_a",    32'(bus.a),    32'd1);
    chk("t1_busy", 32'(bus.busy), 32'd1);
    bus.req = '0;
    tick();                                    // E
    chk("t1_a_clr",   32'(bus.a),   32'd0);
    chk("t1_gnt_clr", 32'(bus.gnt), 32'd0);
    repeat (3) begin
      tick();                                  // E+1..E+3
      chk("t1_busy_wait", 32'(bus.busy), 32'd1);
      chk("t1_done_wait", 32'(bus.done), 32'd0);
    end
    bus.b = 1'b1;
    tick();                                    // E+4
    chk("t1_done", 32'(bus.done), 32'h4);
    chk("t1_err",  32'(bus.err),  32'd0);
    chk("t1_busy_end", 32'(bus.busy), 32'd0);
    bus.b = 1'b0;
    tick();
    chk("t1_done_pulse", 32'(bus.done), 32'd0);

    // ---------------- 2: late error for requester 2
    bus.req = 4'b0100;
    tick();
    chk("t2_gnt", 32'(bus.gnt), 32'h4);
    bus.req = '0;
    tick();                                    // E
    repeat (3) tick();
    tick();                                    // E+4, b still 0
    chk("t2_err",       32'(bus.err),       32'd1);
    chk("t2_err_late",  32'(bus.err_late),  32'd1);
    chk("t2_err_early", 32'(bus.err_early), 32'd0);
    chk("t2_err_id",    32'(bus.err_id),    32'd2);
    chk("t2_done",      32'(bus.done),      32'd0);
    chk("t2_busy",      32'(bus.busy),      32'd0);
    tick();
    chk("t2_err_pulse", 32'(bus.err), 32'd0);

    // ---------------- 3: early error for requester 1
    bus.req = 4'b0010;
    tick();
    chk("t3_gnt", 32'(bus.gnt), 32'h2);
    bus.req = '0;
    tick();                                    // E
    tick();                                    // E+1
    bus.b = 1'b1;
    tick();                                    // E+2
    chk("t3_err",       32'(bus.err),       32'd1);
    chk("t3_err_early", 32'(bus.err_early), 32'd1);
    chk("t3_err_late",  32'(bus.err_late),  32'd0);
    chk("t3_err_id",    32'(bus.err_id),    32'd1);
    chk("t3_busy",      32'(bus.busy),      32'd0);
    bus.b = 1'b0;
    tick();                                    // E+3
    chk("t3_err_pulse", 32'(bus.err), 32'd0);
    bus.b = 1'b1;
    tick();                                    // E+4, b ignored
    chk("t3_late_b_done", 32'(bus.done), 32'd0);
    chk("t3_late_b_err",  32'(bus.err),  32'd0);
    chk("t3_late_b_busy", 32'(bus.busy), 32'd0);
    bus.b = 1'b0;

    // ---------------- 4: all requesting, rotation 0,1,2,3,0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.req = 4'b1111;
    tick();                                    // first issue
    begin
      logic [NREQ-1:0] exp_oh [5];
      exp_oh[0] = 4'b0001;
      exp_oh[1] = 4'b0010;
      exp_oh[2] = 4'b0100;
      exp_oh[3] = 4'b1000;
      exp_oh[4] = 4'b0001;
      for (int t = 0; t < 5; t++) begin
        chk($sformatf("t4_gnt_%0d", t), 32'(bus.gnt), 32'(exp_oh[t]));
        chk($sformatf("t4_a_%0d", t),   32'(bus.a),   32'd1);
        tick();                                // E
        repeat (3) begin
          tick();
          chk($sformatf("t4_nogrant_%0d", t), 32'(bus.a), 32'd0);
        end
        bus.b = 1'b1;
        tick();                                // E+4
        chk($sformatf("t4_done_%0d", t), 32'(bus.done), 32'(exp_oh[t]));
        bus.b = 1'b0;
        if (t == 4) bus.req = '0;
        tick();                                // next issue, 6 edges later
      end
    end
    chk("t4_idle_after", 32'(bus.a), 32'd0);

    // ---------------- 5: reset mid-transaction
    bus.req = 4'b1000;
    tick();
    chk("t5_gnt", 32'(bus.gnt), 32'h8);
    bus.req = '0;
    tick();                                    // E
    tick();                                    // E+1
    tick();                                    // E+2
    rst_n = 1'b0;
    #1;
    chk_quiet("t5_rst");
    tick();                                    // E+3 under reset
    rst_n = 1'b1;
    bus.b = 1'b1;
    tick();                                    // E+4
    chk("t5_no_done", 32'(bus.done), 32'd0);
    chk("t5_no_err",  32'(bus.err),  32'd0);
    chk("t5_no_busy", 32'(bus.busy), 32'd0);
    bus.b   = 1'b0;
    bus.req = 4'b1001;
    tick();
    chk("t5_gnt_ptr", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    tick();                                    // E
    repeat (4) tick();                         // E+4, no b
    chk("t5_late_err", 32'(bus.err),    32'd1);
    chk("t5_late_id",  32'(bus.err_id), 32'd0);
    tick();

    // ---------------- 6: enable gating
    bus.en  = 1'b0;
    bus.req = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("t6_en0_gnt_%0d", i), 32'(bus.gnt), 32'd0);
    end
    bus.en = 1'b1;
    tick();
    chk("t6_gnt", 32'(bus.gnt), 32'h1);
    chk("t6_a",   32'(bus.a),   32'd1);
    tick();                                    // E
    tick();                                    // E+1
    bus.en = 1'b0;
    tick();                                    // E+2
    tick();                                    // E+3
    bus.b = 1'b1;
    tick();                                    // E+4
    chk("t6_done", 32'(bus.done), 32'h1);
    bus.b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("t6_hold_a_%0d", i),    32'(bus.a),    32'd0);
      chk($sformatf("t6_hold_busy_%0d", i), 32'(bus.busy), 32'd0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
